mmio_keyled: RTL and testbench
==============================

# mmio_keyled

Parametrised memory-mapped I/O peripheral for the DE1-SoC environment. It provides an N-bit LED output register with atomic set/clear aliases and M debounced push-button inputs with press-edge capture and a level interrupt. It sits beside the RAM memory map on the core's single memory bus. The block claims a 256-byte window, and the environment top muxes `read_data` using `hit`.

## Interface
- `BASE_ADDR`, 32'h0000_8000: window base; bits [7:0] must be zero.
- `NUM_LEDS`, 10: LED outputs, 1–32.
- `NUM_KEYS`, 4: key inputs, 1–32.
- `DEBOUNCE_CYCLES`, 50000: stable-cycle count before a key change is accepted (1 ms at 50 MHz); must be ≥2.
- `KEY_ACTIVE_LOW`, 1: when 1, raw keys are inverted so that 1 means pressed.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `address` in 32 (`addr_t`): byte address from the core.
- `write_data` in 32 (`data_t`): store data.
- `write_enable` in 1: store strobe, one cycle per store.
- `read_data` out 32 (`data_t`): registered load data.
- `hit` out 1: registered; `read_data` is valid for the previous-cycle address inside the window.
- `keys_in` in `NUM_KEYS`: raw asynchronous key pins.
- `leds_out` out `NUM_LEDS`: LED drive, equal to the LED register.
- `irq` out 1: level interrupt.

## Operation
- Decode: the block is selected when `address[31:8] == BASE_ADDR[31:8]`. The register offset is `address[7:2]`, and `address[1:0]` is ignored. Writes take effect only when selected and `write_enable` is high.
- Register map (byte offset):
  - 0x00 LED: read/write. Writes `write_data[NUM_LEDS-1:0]`; upper bits read as 0.
  - 0x04 LED_SET: write-only. LED |= data. Reads as 0.
  - 0x08 LED_CLR: write-only. LED &= ~data. Reads as 0.
  - 0x0C KEY_STATE: read-only. Debounced pressed state.
  - 0x10 KEY_EDGE: read / write-1-to-clear. Sticky press events.
  - 0x14 IRQ_MASK: read/write, `NUM_KEYS` bits.
  - Unmapped offsets read as 0; writes to them are ignored.
- Key path, per key:
  - A 2-FF synchronizer feeds a polarity-corrected `sync` signal.
  - A counter of width `$clog2(DEBOUNCE_CYCLES)` is cleared on every edge where `sync == stable`.
  - On each edge where `sync != stable`: if `count == DEBOUNCE_CYCLES-1`, then `stable <= sync` and `count <= 0`; otherwise `count++`.
- Edge capture:
  - `KEY_EDGE[i]` is set on the cycle `stable[i]` goes 0→1. Releases are not captured.
  - Set has priority over a same-cycle W1C on the same bit.
- `irq = |(KEY_EDGE & IRQ_MASK)`, registered.
- Reset values:
  - LED = 0, IRQ_MASK = 0, KEY_EDGE = 0.
  - `stable` = 0 (not pressed), counters = 0.
  - Synchronizer flops reset to the unpressed raw level.
  - `read_data` = 0, `hit` = 0, `irq` = 0, `leds_out` = 0.
- Reset asserted mid-operation clears all state immediately. After reset deasserts, a key held down is reported pressed only after a full debounce period, and that report generates an edge.

## Timing
- Loads: `address` is sampled at edge N; `read_data` and `hit` are valid after edge N. This is one-cycle latency, identical to RAM.
- Read-during-write to the same offset returns the pre-write value.
- Stores: the register updates at the edge where `write_enable` is sampled. `leds_out` changes in the same cycle.
- Key latency: a raw change settled before edge 0 is reflected in `stable` after edge `2+DEBOUNCE_CYCLES`. Concretely:
  - `sync` differs after edge 2.
  - The counter runs on edges 3 through 1+`DEBOUNCE_CYCLES`.
  - `stable` updates at edge 2+`DEBOUNCE_CYCLES`.
- `KEY_EDGE` sets one edge after `stable` rises. `irq` asserts one edge after that.
- A glitch that returns to the stable level before the counter completes resets the counter; no change is accepted.
- `hit` deasserts for any address outside the window, and `read_data` is then 0.

## Test plan
1. Reset, then write 0x3FF to LED → `leds_out` = 0x3FF next cycle. Write 0x00F to LED_CLR → 0x3F0. Write 0x001 to LED_SET → 0x3F1. Load offset 0x00 → `read_data` = 0x3F1 and `hit` = 1 one cycle later. Loads of 0x04 and 0x18 → 0.
2. With `DEBOUNCE_CYCLES`=4, drive `keys_in[0]` low (pressed) → KEY_STATE bit0 = 1 after edge 6. KEY_EDGE bit0 = 1 one edge later. With IRQ_MASK = 1, `irq` = 1 one edge after that.
3. Drive a 3-cycle low glitch on `keys_in[1]` with `DEBOUNCE_CYCLES`=4 → KEY_STATE and KEY_EDGE stay 0.
4. With KEY_EDGE = 0x1, write 0x1 to KEY_EDGE on the same cycle a new key0 press edge occurs → bit0 remains 1. A later W1C with no new press → bit0 = 0 and `irq` = 0.
5. Load address `BASE_ADDR`+0x100 → `hit` = 0 and `read_data` = 0. A store to that address leaves all registers unchanged.
6. Hold key2 pressed, assert `reset` low mid-debounce, then release reset → all outputs 0 during reset. After 2+4 cycles, KEY_STATE bit2 = 1 and KEY_EDGE bit2 sets.

Source files
------------

// File: rtl/mmio_keyled.sv
// mmio_keyled: memory-mapped LED output register and debounced push-button inputs.
//
// Register window (256 bytes at BASE_ADDR, offset = address[7:2]):
//   0x00 LED       rw   LED register
//   0x04 LED_SET   wo   LED |= data, reads 0
//   0x08 LED_CLR   wo   LED &= ~data, reads 0
//   0x0C KEY_STATE ro   debounced pressed state
//   0x10 KEY_EDGE  rw1c sticky press events (new press wins over same-cycle clear)
//   0x14 IRQ_MASK  rw   per-key interrupt enable
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   address      byte address from the core
//   write_data   store data
//   write_enable one-cycle store strobe
//   read_data    registered load data (0 outside the window / unmapped offsets)
//   hit          registered: previous-cycle address was inside the window
//   keys_in      raw asynchronous key pins
//   leds_out     LED drive
//   irq          registered level interrupt, |(KEY_EDGE & IRQ_MASK)
module mmio_keyled #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_8000,
  parameter int unsigned NUM_LEDS        = 10,
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         address,
  input  logic [31:0]         write_data,
  input  logic                write_enable,
  output logic [31:0]         read_data,
  output logic                hit,
  input  logic [NUM_KEYS-1:0] keys_in,
  output logic [NUM_LEDS-1:0] leds_out,
  output logic                irq
);

  localparam int unsigned     CntW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  // Raw pin level meaning "not pressed"; synchronizers reset to it.
  localparam logic [NUM_KEYS-1:0] RawIdle = {NUM_KEYS{KEY_ACTIVE_LOW}};

  localparam logic [5:0] OffLed    = 6'h00;
  localparam logic [5:0] OffLedSet = 6'h01;
  localparam logic [5:0] OffLedClr = 6'h02;
  localparam logic [5:0] OffKeySt  = 6'h03;
  localparam logic [5:0] OffKeyEdg = 6'h04;
  localparam logic [5:0] OffIrqMsk = 6'h05;

  logic                           sel;
  logic                           wr;
  logic [5:0]                     off;
  logic                           unused_bits;

  logic [NUM_LEDS-1:0]            led_q, led_d;
  logic [NUM_KEYS-1:0]            mask_q, mask_d;
  logic [NUM_KEYS-1:0]            edge_q, edge_d;
  logic [NUM_KEYS-1:0]            sync1_q, sync2_q, sync;
  logic [NUM_KEYS-1:0]            stable_q, stable_d, stable_prev_q;
  logic [NUM_KEYS-1:0][CntW-1:0]  cnt_q, cnt_d;
  logic [31:0]                    rdata_d;
  logic                           irq_d;

  assign sel         = (address[31:8] == BASE_ADDR[31:8]);
  assign off         = address[7:2];
  assign wr          = sel & write_enable;
  assign unused_bits = ^{address[1:0], write_data};

  assign sync = KEY_ACTIVE_LOW ? ~sync2_q : sync2_q;

  // Debounce: any cycle where sync matches stable restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      cnt_d[i] = '0;
      if (sync[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_comb begin
    led_d  = led_q;
    mask_d = mask_q;
    edge_d = edge_q;
    if (wr) begin
      case (off)
        OffLed:    led_d  = write_data[NUM_LEDS-1:0];
        OffLedSet: led_d  = led_q | write_data[NUM_LEDS-1:0];
        OffLedClr: led_d  = led_q & ~write_data[NUM_LEDS-1:0];
        OffKeyEdg: edge_d = edge_q & ~write_data[NUM_KEYS-1:0];
        OffIrqMsk: mask_d = write_data[NUM_KEYS-1:0];
        default: ;
      endcase
    end
    // Applied after the clear so a new press survives a same-cycle W1C.
    edge_d = edge_d | (stable_q & ~stable_prev_q);
  end

  always_comb begin
    rdata_d = '0;
    if (sel) begin
      case (off)
        OffLed:    rdata_d[NUM_LEDS-1:0] = led_q;
        OffKeySt:  rdata_d[NUM_KEYS-1:0] = stable_q;
        OffKeyEdg: rdata_d[NUM_KEYS-1:0] = edge_q;
        OffIrqMsk: rdata_d[NUM_KEYS-1:0] = mask_q;
        default: ;
      endcase
    end
  end

  assign irq_d = |(edge_q & mask_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q         <= '0;
      mask_q        <= '0;
      edge_q        <= '0;
      sync1_q       <= RawIdle;
      sync2_q       <= RawIdle;
      stable_q      <= '0;
      stable_prev_q <= '0;
      cnt_q         <= '0;
      read_data     <= '0;
      hit           <= 1'b0;
      irq           <= 1'b0;
    end else begin
      led_q         <= led_d;
      mask_q        <= mask_d;
      edge_q        <= edge_d;
      sync1_q       <= keys_in;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
      read_data     <= rdata_d;
      hit           <= sel;
      irq           <= irq_d;
    end
  end

  assign leds_out = led_q;

endmodule

// File: tb/tb_mmio_keyled.sv
module tb_mmio_keyled;

  localparam logic [31:0] Base      = 32'h0000_8000;
  localparam logic [31:0] OffLed    = 32'h00;
  localparam logic [31:0] OffLedSet = 32'h04;
  localparam logic [31:0] OffLedClr = 32'h08;
  localparam logic [31:0] OffKeySt  = 32'h0C;
  localparam logic [31:0] OffKeyEdg = 32'h10;
  localparam logic [31:0] OffIrqMsk = 32'h14;
  localparam logic [31:0] OffHole   = 32'h18;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        write_enable;
  logic [31:0] read_data;
  logic        hit;
  logic [3:0]  keys_in;
  logic [9:0]  leds_out;
  logic        irq;

  int checks = 0;
  int errors = 0;

  mmio_keyled #(
    .BASE_ADDR       (Base),
    .NUM_LEDS        (10),
    .NUM_KEYS        (4),
    .DEBOUNCE_CYCLES (4),
    .KEY_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .write_data   (write_data),
    .write_enable (write_enable),
    .read_data    (read_data),
    .hit          (hit),
    .keys_in      (keys_in),
    .leds_out     (leds_out),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    address      = a;
    write_data   = d;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a);
    address      = a;
    write_enable = 1'b0;
    tick();
  endtask

  initial begin
    reset        = 1'b0;
    keys_in      = 4'hF;
    address      = Base + OffLed;
    write_data   = 32'hFFFF_FFFF;
    write_enable = 1'b1;
    tick();
    tick();
    check("rst_leds", 32'(leds_out), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rdata", read_data, 32'h0);
    check("rst_hit", 32'(hit), 32'h0);
    write_enable = 1'b0;
    reset        = 1'b1;

    // LED register and aliases
    bus_write(Base + OffLed, 32'h3FF);
    check("led_write", 32'(leds_out), 32'h3FF);
    bus_write(Base + OffLedClr, 32'h00F);
    check("led_clr", 32'(leds_out), 32'h3F0);
    bus_write(Base + OffLedSet, 32'h001);
    check("led_set", 32'(leds_out), 32'h3F1);
    bus_read(Base + OffLed);
    check("led_read", read_data, 32'h3F1);
    check("led_read_hit", 32'(hit), 32'h1);
    bus_read(Base + OffLed + 32'h3);
    check("led_read_lowbits", read_data, 32'h3F1);
    bus_read(Base + OffLedSet);
    check("set_reads_zero", read_data, 32'h0);
    bus_read(Base + OffHole);
    check("hole_reads_zero", read_data, 32'h0);
    check("hole_hit", 32'(hit), 32'h1);
    bus_write(Base + OffLed, 32'hFFFF_F2AA);
    check("rdw_old_value", read_data, 32'h3F1);
    check("rdw_leds", 32'(leds_out), 32'h2AA);

    // Key0 press: stable at edge 6, visible in a load sampled at edge 7
    bus_write(Base + OffIrqMsk, 32'h1);
    address    = Base + OffKeySt;
    keys_in[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("key0_wait_e%0d", k), read_data, 32'h0);
    end
    tick();
    check("key0_state", read_data, 32'h1);
    check("key0_irq_early", 32'(irq), 32'h0);
    address = Base + OffKeyEdg;
    tick();
    check("key0_edge", read_data, 32'h1);
    check("key0_irq", 32'(irq), 32'h1);

    // 3-cycle glitch on key1 must be rejected
    keys_in[1] = 1'b0;
    repeat (3) tick();
    keys_in[1] = 1'b1;
    address    = Base + OffKeySt;
    repeat (10) tick();
    check("glitch_state", read_data, 32'h1);
    address = Base + OffKeyEdg;
    tick();
    check("glitch_edge", read_data, 32'h1);

    // Release not captured; new press beats same-cycle W1C
    keys_in[0] = 1'b1;
    address    = Base + OffKeySt;
    repeat (10) tick();
    check("release_state", read_data, 32'h0);
    address = Base + OffKeyEdg;
    tick();
    check("release_edge", read_data, 32'h1);
    keys_in[0] = 1'b0;
    repeat (6) tick();
    bus_write(Base + OffKeyEdg, 32'h1);
    tick();
    check("w1c_vs_set", read_data, 32'h1);
    check("w1c_vs_set_irq", 32'(irq), 32'h1);
    bus_write(Base + OffKeyEdg, 32'h1);
    bus_read(Base + OffKeyEdg);
    check("w1c_clear", read_data, 32'h0);
    check("w1c_irq", 32'(irq), 32'h0);

    // Outside the window
    bus_read(Base + 32'h100);
    check("miss_hit", 32'(hit), 32'h0);
    check("miss_rdata", read_data, 32'h0);
    bus_write(Base + 32'h100 + OffLed, 32'h0);
    bus_write(Base + 32'h100 + OffIrqMsk, 32'h0);
    bus_write(Base + OffHole, 32'hFFFF_FFFF);
    check("miss_store_leds", 32'(leds_out), 32'h2AA);
    bus_read(Base + OffIrqMsk);
    check("miss_store_mask", read_data, 32'h1);
    bus_read(Base + OffHole);
    check("hole_store_ignored", read_data, 32'h0);

    // Reset mid-debounce with key2 held
    keys_in = 4'b1011;
    address = Base + OffKeySt;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("mid_rst_leds", 32'(leds_out), 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    check("mid_rst_rdata", read_data, 32'h0);
    check("mid_rst_hit", 32'(hit), 32'h0);
    tick();
    check("mid_rst_hit_clk", 32'(hit), 32'h0);
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("key2_wait_e%0d", k), read_data, 32'h0);
    end
    tick();
    check("key2_state", read_data, 32'h4);
    address = Base + OffKeyEdg;
    tick();
    check("key2_edge", read_data, 32'h4);
    bus_read(Base + OffIrqMsk);
    check("post_rst_mask", read_data, 32'h0);
    check("post_rst_irq", 32'(irq), 32'h0);
    check("post_rst_leds", 32'(leds_out), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
